// File: rtl/sc_cfg_pkg.sv
// Shared types and constants for the scanconverter config sequencer.
package sc_cfg_pkg;
    localparam int NUM_CFG_REGS = 8;

    localparam int CFG_HV1  = 0;
    localparam int CFG_HV2  = 1;
    localparam int CFG_HV3  = 2;
    localparam int CFG_XY1  = 3;
    localparam int CFG_XY2  = 4;
    localparam int CFG_MISC = 5;
    localparam int CFG_SL1  = 6;
    localparam int CFG_SL2  = 7;

    typedef logic [31:0] cfg_word_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT,
        SETTLE
    } sc_state_e;
endpackage

// File: rtl/sc_config_sequencer_if.sv
// CPU register-bridge side of the config sequencer: staging writes, commit
// request and status read-back.
interface sc_config_sequencer_if
    import sc_cfg_pkg::*;
#(
    parameter int MUTE_W = 3
);
    logic              cfg_wr_i;
    logic [3:0]        cfg_addr_i;
    cfg_word_t         cfg_data_i;
    logic              commit_req_i;
    logic [MUTE_W-1:0] mute_frames_i;
    logic              busy_o;
    logic              commit_done_o;
    logic              timeout_o;

    modport master (
        output cfg_wr_i, cfg_addr_i, cfg_data_i, commit_req_i, mute_frames_i,
        input  busy_o, commit_done_o, timeout_o
    );

    modport slave (
        input  cfg_wr_i, cfg_addr_i, cfg_data_i, commit_req_i, mute_frames_i,
        output busy_o, commit_done_o, timeout_o
    );
endinterface

// File: rtl/sc_vsync_edge_det.sv
// Falling-edge detector for the active-low output VSYNC.
module sc_vsync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic vs_fall
);
    logic vs_prev;

    // Previous VSYNC level; resets high so a low VSYNC out of reset is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vs_prev <= 1'b1;
        else     vs_prev <= vsync;
    end

    assign vs_fall = vs_prev & ~vsync;
endmodule

// File: rtl/sc_config_sequencer.sv
// Shadow-register controller: CPU writes staging words at any time; a commit
// waits for an output frame boundary, copies staging to active atomically and
// then mutes video for a programmable number of frames.
module sc_config_sequencer
    import sc_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int MUTE_W         = 3
) (
    input  logic                 PCLK_OUT_i,
    input  logic                 reset_i,
    sc_config_sequencer_if.slave cpu,
    input  logic                 VSYNC_i,
    output cfg_word_t            hv_out_config_o,
    output cfg_word_t            hv_out_config2_o,
    output cfg_word_t            hv_out_config3_o,
    output cfg_word_t            xy_out_config_o,
    output cfg_word_t            xy_out_config2_o,
    output cfg_word_t            misc_config_o,
    output cfg_word_t            sl_config_o,
    output cfg_word_t            sl_config2_o,
    output logic                 mute_o
);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    sc_state_e         state_q, state_d;
    cfg_word_t         staging_q [NUM_CFG_REGS];
    cfg_word_t         active_q  [NUM_CFG_REGS];
    logic [TW-1:0]     tmo_cnt_q;
    logic [MUTE_W-1:0] mute_cnt_q;
    logic              pending_q, force_q, timeout_q, done_q, mute_q;
    logic              vs_fall, arm, force_hit, mute_nz;

    sc_vsync_edge_det u_edge (
        .clk     (PCLK_OUT_i),
        .rst     (reset_i),
        .vsync   (VSYNC_i),
        .vs_fall (vs_fall)
    );

    assign mute_nz = |cpu.mute_frames_i;

    // State register.
    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state; a VSYNC edge wins over the timeout, so force only marks a
    // commit that really had no frame boundary.
    always_comb begin
        state_d   = state_q;
        arm       = 1'b0;
        force_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu.commit_req_i || pending_q) begin
                    state_d = ARMED;
                    arm     = 1'b1;
                end
            end
            ARMED: begin
                if (vs_fall) begin
                    state_d = COMMIT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = COMMIT;
                    force_hit = 1'b1;
                end
            end
            COMMIT: state_d = mute_nz ? SETTLE : IDLE;
            SETTLE: begin
                if (vs_fall && (mute_cnt_q == MUTE_W'(1))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter, pending commit, mute frame count and status flags.
    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            tmo_cnt_q  <= '0;
            mute_cnt_q <= '0;
            pending_q  <= 1'b0;
            force_q    <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            mute_q     <= 1'b1;
        end else begin
            done_q <= (state_q == COMMIT);
            unique case (state_q)
                IDLE: begin
                    if (arm) begin
                        tmo_cnt_q <= '0;
                        pending_q <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                ARMED: begin
                    force_q <= force_hit;
                    if (!vs_fall && !force_hit) tmo_cnt_q <= tmo_cnt_q + TW'(1);
                end
                COMMIT: begin
                    mute_cnt_q <= cpu.mute_frames_i;
                    timeout_q  <= force_q;
                    mute_q     <= mute_nz;
                end
                SETTLE: begin
                    if (cpu.commit_req_i) pending_q <= 1'b1;
                    if (vs_fall) begin
                        mute_cnt_q <= mute_cnt_q - MUTE_W'(1);
                        if (mute_cnt_q == MUTE_W'(1)) mute_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Staging writes are accepted in every state; addresses 8..15 are dropped.
    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) staging_q[i] <= '0;
        end else if (cpu.cfg_wr_i && !cpu.cfg_addr_i[3]) begin
            staging_q[cpu.cfg_addr_i[2:0]] <= cpu.cfg_data_i;
        end
    end

    // Atomic copy in the COMMIT cycle; a same-cycle write is not seen here.
    always_ff @(posedge PCLK_OUT_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) active_q[i] <= '0;
        end else if (state_q == COMMIT) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) active_q[i] <= staging_q[i];
        end
    end

    assign hv_out_config_o   = active_q[CFG_HV1];
    assign hv_out_config2_o  = active_q[CFG_HV2];
    assign hv_out_config3_o  = active_q[CFG_HV3];
    assign xy_out_config_o   = active_q[CFG_XY1];
    assign xy_out_config2_o  = active_q[CFG_XY2];
    assign misc_config_o     = active_q[CFG_MISC];
    assign sl_config_o       = active_q[CFG_SL1];
    assign sl_config2_o      = active_q[CFG_SL2];

    assign mute_o            = mute_q;
    assign cpu.busy_o        = (state_q != IDLE);
    assign cpu.commit_done_o = done_q;
    assign cpu.timeout_o     = timeout_q;
endmodule

// File: tb/tb_sc_config_sequencer.sv
// Bench for sc_config_sequencer: spec vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_sc_config_sequencer;
    import sc_cfg_pkg::*;

    localparam int TMO = 16;
    localparam int MW  = 3;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      vs  = 1'b1;
    logic      mute;
    cfg_word_t dout [NUM_CFG_REGS];

    int n_chk  = 0;
    int n_fail = 0;

    sc_config_sequencer_if #(.MUTE_W(MW)) bus ();

    sc_config_sequencer #(.TIMEOUT_CYCLES(TMO), .MUTE_W(MW)) dut (
        .PCLK_OUT_i       (clk),
        .reset_i          (rst),
        .cpu              (bus),
        .VSYNC_i          (vs),
        .hv_out_config_o  (dout[CFG_HV1]),
        .hv_out_config2_o (dout[CFG_HV2]),
        .hv_out_config3_o (dout[CFG_HV3]),
        .xy_out_config_o  (dout[CFG_XY1]),
        .xy_out_config2_o (dout[CFG_XY2]),
        .misc_config_o    (dout[CFG_MISC]),
        .sl_config_o      (dout[CFG_SL1]),
        .sl_config2_o     (dout[CFG_SL2]),
        .mute_o           (mute)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Tracks the commit as a transaction: waiting for a frame boundary,
    // copy scheduled for the next cycle, then a number of frames to sit out.
    cfg_word_t m_stage [NUM_CFG_REGS];
    cfg_word_t m_act   [NUM_CFG_REGS];
    bit m_vs_last, m_waiting, m_copy, m_settling, m_queued, m_forced;
    bit m_timeout, m_mute, m_done;
    int m_wait, m_frames;

    task automatic model_reset();
        for (int i = 0; i < NUM_CFG_REGS; i++) begin
            m_stage[i] = '0;
            m_act[i]   = '0;
        end
        m_vs_last = 1; m_waiting = 0; m_copy = 0; m_settling = 0; m_queued = 0;
        m_forced = 0; m_timeout = 0; m_mute = 1; m_done = 0;
        m_wait = 0; m_frames = 0;
    endtask

    task automatic model_step();
        bit fall, done_n;
        int mf;
        fall   = m_vs_last && !vs;
        done_n = 0;
        mf     = int'(bus.mute_frames_i);
        if (m_copy) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) m_act[i] = m_stage[i];
            done_n     = 1;
            m_timeout  = m_forced;
            m_mute     = (mf != 0);
            m_frames   = mf;
            m_settling = (mf != 0);
            m_copy     = 0;
        end else if (m_waiting) begin
            if (fall) begin
                m_copy = 1; m_forced = 0; m_waiting = 0;
            end else if (m_wait == TMO - 1) begin
                m_copy = 1; m_forced = 1; m_waiting = 0;
            end else begin
                m_wait++;
            end
        end else if (m_settling) begin
            if (bus.commit_req_i) m_queued = 1;
            if (fall) begin
                m_frames--;
                if (m_frames == 0) begin
                    m_settling = 0;
                    m_mute     = 0;
                end
            end
        end else if (bus.commit_req_i || m_queued) begin
            m_waiting = 1; m_wait = 0; m_queued = 0; m_timeout = 0;
        end
        if (bus.cfg_wr_i && bus.cfg_addr_i < 4'd8) m_stage[bus.cfg_addr_i[2:0]] = bus.cfg_data_i;
        m_vs_last = vs;
        m_done    = done_n;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        for (int i = 0; i < NUM_CFG_REGS; i++)
            chk($sformatf("mdl_word%0d", i), dout[i], m_act[i]);
        chk("mdl_busy",    32'(bus.busy_o),        32'(m_waiting | m_copy | m_settling));
        chk("mdl_done",    32'(bus.commit_done_o), 32'(m_done));
        chk("mdl_mute",    32'(mute),              32'(m_mute));
        chk("mdl_timeout", 32'(bus.timeout_o),     32'(m_timeout));
    endtask

    // One clock: model advances on the same inputs, outputs sampled 1 ns later,
    // write/commit strobes are one-shot.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        bus.cfg_wr_i     = 1'b0;
        bus.commit_req_i = 1'b0;
        compare_model();
    endtask

    task automatic vs_high(input int n);
        vs = 1'b1;
        repeat (n) tick();
    endtask

    task automatic vs_fall_tick();
        vs = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [3:0] a, input cfg_word_t d);
        bus.cfg_wr_i   = 1'b1;
        bus.cfg_addr_i = a;
        bus.cfg_data_i = d;
    endtask

    // ---------------- spec vector table ----------------
    typedef struct {
        logic      wr;
        logic [3:0] addr;
        cfg_word_t data;
        logic      req;
        logic [MW-1:0] mf;
        logic      vsync;
        cfg_word_t e_hv;
        cfg_word_t e_sl2;
        logic      e_done;
        logic      e_mute;
        logic      e_busy;
    } vec_t;

    vec_t tbl [7];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int vcnt, vper;
        bus.cfg_wr_i      = 1'b0;
        bus.cfg_addr_i    = '0;
        bus.cfg_data_i    = '0;
        bus.commit_req_i  = 1'b0;
        bus.mute_frames_i = '0;
        model_reset();

        tbl[0] = '{1'b1, 4'd0, 32'h12345678, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 4'd7, 32'hCAFEBABE, 1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 4'd0, 32'h0,        1'b1, 3'd0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 4'd0, 32'h0,        1'b0, 3'd0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 4'd0, 32'h0,        1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 4'd0, 32'h0,        1'b0, 3'd0, 1'b0, 32'h12345678, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 4'd0, 32'h0,        1'b0, 3'd0, 1'b1, 32'h12345678, 32'hCAFEBABE, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hv",      dout[CFG_HV1], 32'h0);
        chk("rst_sl2",     dout[CFG_SL2], 32'h0);
        chk("rst_mute",    32'(mute), 32'h1);
        chk("rst_busy",    32'(bus.busy_o), 32'h0);
        chk("rst_done",    32'(bus.commit_done_o), 32'h0);
        chk("rst_timeout", 32'(bus.timeout_o), 32'h0);
        rst = 1'b0;

        // Basic commit on a VSYNC edge, mute_frames=0.
        for (int r = 0; r < 7; r++) begin
            bus.cfg_wr_i      = tbl[r].wr;
            bus.cfg_addr_i    = tbl[r].addr;
            bus.cfg_data_i    = tbl[r].data;
            bus.commit_req_i  = tbl[r].req;
            bus.mute_frames_i = tbl[r].mf;
            vs                = tbl[r].vsync;
            tick();
            chk($sformatf("tbl%0d_hv", r),   dout[CFG_HV1], tbl[r].e_hv);
            chk($sformatf("tbl%0d_sl2", r),  dout[CFG_SL2], tbl[r].e_sl2);
            chk($sformatf("tbl%0d_done", r), 32'(bus.commit_done_o), 32'(tbl[r].e_done));
            chk($sformatf("tbl%0d_mute", r), 32'(mute), 32'(tbl[r].e_mute));
            chk($sformatf("tbl%0d_busy", r), 32'(bus.busy_o), 32'(tbl[r].e_busy));
        end

        // Commit with three mute frames.
        bus.mute_frames_i = 3'd3;
        bus.commit_req_i  = 1'b1;
        tick();
        vs_fall_tick();
        chk("m3_commit_mute", 32'(mute), 32'h0);
        tick();
        chk("m3_mute_on", 32'(mute), 32'h1);
        chk("m3_busy_on", 32'(bus.busy_o), 32'h1);
        vs_high(3);
        for (int k = 1; k <= 3; k++) begin
            vs_fall_tick();
            chk($sformatf("m3_edge%0d_mute", k), 32'(mute), (k < 3) ? 32'h1 : 32'h0);
            chk($sformatf("m3_edge%0d_busy", k), 32'(bus.busy_o), (k < 3) ? 32'h1 : 32'h0);
            vs_high(3);
        end

        // Forced commit with VSYNC held high.
        bus.mute_frames_i = '0;
        wr(4'd2, 32'h33333333);
        tick();
        bus.commit_req_i = 1'b1;
        tick();
        repeat (15) tick();
        chk("tmo_busy_armed", 32'(bus.busy_o), 32'h1);
        tick();
        chk("tmo_hv3_old", dout[CFG_HV3], 32'h0);
        tick();
        chk("tmo_hv3_new", dout[CFG_HV3], 32'h33333333);
        chk("tmo_flag", 32'(bus.timeout_o), 32'h1);
        chk("tmo_done", 32'(bus.commit_done_o), 32'h1);
        bus.commit_req_i = 1'b1;
        tick();
        chk("tmo_clear", 32'(bus.timeout_o), 32'h0);
        vs_high(2);
        vs_fall_tick();
        vs_high(3);

        // Write during the COMMIT cycle lands in staging only.
        wr(4'd3, 32'h11110000);
        tick();
        bus.commit_req_i = 1'b1;
        tick();
        vs_high(2);
        vs_fall_tick();
        wr(4'd3, 32'hAAAA0000);
        tick();
        chk("wc_xy_prior", dout[CFG_XY1], 32'h11110000);
        vs_high(3);
        bus.commit_req_i = 1'b1;
        tick();
        vs_high(2);
        vs_fall_tick();
        tick();
        chk("wc_xy_new", dout[CFG_XY1], 32'hAAAA0000);
        vs_high(3);

        // Commit request during SETTLE becomes pending; address 9 is ignored.
        bus.mute_frames_i = 3'd2;
        bus.commit_req_i  = 1'b1;
        tick();
        vs_fall_tick();
        vs = 1'b1;
        tick();
        bus.commit_req_i = 1'b1;
        wr(4'd9, 32'hDEADBEEF);
        tick();
        vs_high(2);
        vs_fall_tick();
        vs_high(3);
        vs_fall_tick();
        chk("pend_idle", 32'(bus.busy_o), 32'h0);
        vs = 1'b1;
        tick();
        chk("pend_armed", 32'(bus.busy_o), 32'h1);
        vs_high(2);
        bus.mute_frames_i = '0;
        vs_fall_tick();
        tick();
        chk("pend_commit_done", 32'(bus.commit_done_o), 32'h1);
        chk("addr9_hv2", dout[CFG_HV2], 32'h0);
        chk("addr9_xy", dout[CFG_XY1], 32'hAAAA0000);
        vs_high(3);

        // Asynchronous reset in the middle of ARMED.
        bus.commit_req_i = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hv",      dout[CFG_HV1], 32'h0);
        chk("arst_xy",      dout[CFG_XY1], 32'h0);
        chk("arst_sl2",     dout[CFG_SL2], 32'h0);
        chk("arst_mute",    32'(mute), 32'h1);
        chk("arst_busy",    32'(bus.busy_o), 32'h0);
        chk("arst_done",    32'(bus.commit_done_o), 32'h0);
        chk("arst_timeout", 32'(bus.timeout_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        vcnt = 0;
        vper = 20;
        for (int c = 0; c < 2500; c++) begin
            if (vcnt == 0) vper = int'($urandom_range(6, 40));
            vs = (vcnt < 2) ? 1'b0 : 1'b1;
            vcnt++;
            if (vcnt >= vper) vcnt = 0;
            bus.cfg_wr_i      = ($urandom_range(0, 9) < 3);
            bus.cfg_addr_i    = 4'($urandom_range(0, 15));
            bus.cfg_data_i    = $urandom;
            bus.commit_req_i  = ($urandom_range(0, 19) == 0);
            bus.mute_frames_i = MW'($urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sc_config_sequencer.md
Name: sc_config_sequencer

Overview:
- Shadow-register controller for the scanconverter's eight 32-bit output configuration words: hv_out_config, hv_out_config2, hv_out_config3, xy_out_config, xy_out_config2, misc_config, sl_config and sl_config2.
- The CPU side writes staging registers at any time.
- On a commit request the block waits for the next output-frame boundary (falling edge of the scanconverter's VSYNC_o), copies staging to active atomically, then mutes video for a programmable number of frames while the mode settles.
- Sits in the PCLK_OUT domain between the CPU register bridge and the scanconverter config inputs.

Parameters:
- TIMEOUT_CYCLES, 2000000: cycles to wait in ARMED for a VSYNC edge before a forced commit; minimum 2.
- MUTE_W, 3: width of the mute frame counter.

Ports:
- PCLK_OUT_i  in  1  single clock, output pixel clock.
- reset_i  in  1  asynchronous, active-high reset.
- cfg_wr_i  in  1  staging write strobe.
- cfg_addr_i  in  4  staging index; 0..7 valid, 8..15 ignored.
- cfg_data_i  in  32  staging write data.
- commit_req_i  in  1  single-cycle commit request.
- mute_frames_i  in  MUTE_W  frames to mute after a commit; sampled in the COMMIT cycle.
- VSYNC_i  in  1  scanconverter VSYNC_o, active-low.
- hv_out_config_o, hv_out_config2_o, hv_out_config3_o, xy_out_config_o, xy_out_config2_o, misc_config_o, sl_config_o, sl_config2_o  out  32 each  active config words.
- busy_o  out  1  state != IDLE.
- commit_done_o  out  1  one-cycle pulse when active registers change.
- timeout_o  out  1  sticky: last commit was forced.
- mute_o  out  1  blank video; the top level ORs it into the scanconverter mask.

Behaviour:
- Reset values:
  - All staging and active registers 0.
  - mute_o=1; busy_o=0; commit_done_o=0; timeout_o=0; state IDLE; pending=0.
- Edge detect:
  - vs_prev <= VSYNC_i each cycle.
  - edge = vs_prev & ~VSYNC_i.
  - vs_prev resets to 1.
- Writes:
  - cfg_wr_i with addr<8 updates staging[addr] on the next edge, in every state.
  - A write in the COMMIT cycle lands in staging only; the copy uses pre-write staging contents.
- States:
  - IDLE: commit_req_i -> ARMED; the timeout counter clears.
  - ARMED:
    - edge -> COMMIT.
    - Counter reaches TIMEOUT_CYCLES-1 -> COMMIT with force=1.
    - Otherwise counter++.
    - An edge in the same cycle as IDLE->ARMED is not counted.
    - commit_req_i is ignored.
  - COMMIT (1 cycle):
    - active <= staging for all 8 words.
    - mute_cnt <= mute_frames_i.
    - timeout_o <= force.
    - commit_done_o=1 in the following cycle.
    - Next state is SETTLE if mute_frames_i!=0, else IDLE.
  - SETTLE:
    - mute_o=1.
    - Each edge decrements mute_cnt; on the edge where mute_cnt==1 -> IDLE, and mute_o=0 from the next cycle.
    - commit_req_i sets pending.
  - IDLE entry with pending=1 -> ARMED on the next cycle, pending clears.
- mute_o:
  - Rises on the cycle after COMMIT.
  - With mute_frames_i=0 it falls on that same cycle; a power-on mute_o=1 therefore clears at the first commit.
- timeout_o clears on the next accepted commit_req_i.
- Latency: VSYNC falling at cycle N (edge seen at N), COMMIT at N+1, new active values and commit_done_o at N+2.
- Reset mid-operation: immediate return to the reset state; active registers revert to 0.

Decomposition:
- Package sc_cfg_pkg:
  - NUM_CFG_REGS=8.
  - Index constants CFG_HV1..CFG_SL2 (0..7).
  - State enum {IDLE, ARMED, COMMIT, SETTLE}.
- One sub-module, sc_vsync_edge_det: edge register plus edge pulse, reused by the frame-count logic.

Test Plan:
- Write addr0=0x12345678 and addr7=0xCAFEBABE, then commit_req with mute_frames=0. VSYNC falls at cycle 100. Expect outputs unchanged through cycle 101; hv_out_config_o=0x12345678, sl_config2_o=0xCAFEBABE and commit_done_o=1 at cycle 102; mute_o 1->0 at 102.
- Commit with mute_frames=3. Expect mute_o=1 from the commit until the cycle after the 3rd subsequent VSYNC falling edge, then 0; busy_o low the same cycle.
- TIMEOUT_CYCLES=16, commit_req with VSYNC held high. Expect forced commit with active values updated 17 cycles after ARMED entry and timeout_o=1; a new commit_req clears it.
- Write addr3=0xAAAA0000 in the COMMIT cycle. Expect xy_out_config_o to keep its prior staged value; a second commit with VSYNC edge shows 0xAAAA0000.
- commit_req during SETTLE (mute_frames=2). Expect pending set and ARMED re-entered one cycle after IDLE; a write to addr 9 changes nothing.
- Assert reset_i asynchronously mid-ARMED. Expect all outputs 0, mute_o=1 and busy_o=0 without waiting for a clock edge.
